segre_mem_arbiter: RTL and testbench
====================================

# segre_mem_arbiter

Sequences the single main-memory lane port of the Segre core between three requesters: instruction-cache fill, data-cache fill and data-cache writeback. It sits between the cache miss/writeback logic and the memory interface. It arbitrates the requests and serialises them into one outstanding transaction at a time. It returns fill data and completion pulses to the winning requester.

## Interface
Parameters:
- ADDR_SIZE, 32, address width
- LANE_SIZE, 128, cache lane width in bits (16 bytes)
- STARVE_LIMIT, 4, consecutive lost arbitrations after which the IC fill wins unconditionally

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rsn_i  in  1  reset, asynchronous, active-low
- ic_req_i  in  1  IC fill request; level, held until ic_done_o
- ic_addr_i  in  ADDR_SIZE  IC miss address
- ic_done_o  out  1  one-cycle pulse, IC fill data valid
- ic_data_o  out  LANE_SIZE  IC fill lane
- dc_req_i  in  1  DC fill request; level
- dc_addr_i  in  ADDR_SIZE  DC miss address
- dc_done_o  out  1  one-cycle pulse, DC fill data valid
- dc_data_o  out  LANE_SIZE  DC fill lane
- wb_req_i  in  1  DC writeback request; level
- wb_addr_i  in  ADDR_SIZE  writeback address
- wb_data_i  in  LANE_SIZE  writeback lane
- wb_done_o  out  1  one-cycle pulse, writeback accepted by memory
- mem_rd_o  out  1  memory read strobe, held until mem_ready_i
- mem_wr_o  out  1  memory write strobe, held until mem_ready_i
- mem_addr_o  out  ADDR_SIZE  lane-aligned address, bits [3:0] forced 0
- mem_wr_data_o  out  LANE_SIZE  write lane
- mem_rd_data_i  in  LANE_SIZE  read lane, valid with mem_ready_i
- mem_ready_i  in  1  memory completion, one cycle
- busy_o  out  1  transaction in flight (state BUSY)
- owner_o  out  2  current owner, arb_owner_e

## Operation
- FSM arb_fsm_state_e with three states: ARB_IDLE, ARB_BUSY and ARB_DONE.
- ARB_IDLE: if any req_i is high, a winner is picked. The FSM registers owner, address and write data, asserts mem_rd_o (IC/DC) or mem_wr_o (WB), and moves to ARB_BUSY. With no request it stays in ARB_IDLE.
- Fixed priority: WB > DC > IC. WB goes first so a dirty victim leaves before its replacement fill.
- Starvation counter, 0..STARVE_LIMIT:
  - Increments when ic_req_i is high and another requester wins.
  - Clears when IC wins.
  - At STARVE_LIMIT, IC wins regardless of priority.
  - Saturates; it never wraps.
- ARB_BUSY: mem_* outputs are held stable. When mem_ready_i is sampled high (including in the first BUSY cycle):
  - The strobes drop.
  - The owner's done_o pulses next cycle (registered). Read data is latched into that requester's data_o.
  - The FSM moves to ARB_DONE.
- ARB_DONE: unconditional move to ARB_IDLE. Requests are ignored in this cycle, so the previous owner's still-high req_i is not re-granted.
- Requesters drop req_i the cycle after done_o.
- mem_ready_i in ARB_IDLE or ARB_DONE is ignored.
- Changes to a winner's addr/data inputs after the grant are ignored, because they are registered.
- ic_data_o and dc_data_o hold their last value until the next fill for that requester.

## Timing
- Reset value of every output is 0. State resets to ARB_IDLE, owner to OWN_NONE, starvation counter to 0.
- Reset mid-transaction abandons the transaction: no done pulse is issued, and the memory side must discard it.
- Latency:
  - Request high in IDLE at cycle 0 → strobe at cycle 1.
  - mem_ready_i at cycle N → done_o at cycle N+1, state IDLE at cycle N+2.
  - Minimum round trip is 3 cycles.
- Back-to-back throughput is one transaction per 3 cycles plus memory latency.
- Simultaneous requests in IDLE are resolved in that same cycle. Only one grant is ever issued.

## Configuration
- SEGRE_MEM_ARB_RR_EN:
  - Defined: round-robin arbitration over the order WB, DC, IC. The search starts after the last winner. The starvation counter and STARVE_LIMIT are compiled out.
  - Undefined: fixed priority with the IC starvation counter, as above.

## Structure
- Shared package additions:
  - arb_owner_e {OWN_NONE, OWN_IC, OWN_DC, OWN_WB}
  - arb_fsm_state_e
  - MEM_ARB_STARVE_LIMIT, default for STARVE_LIMIT
- The lane width comes from ICACHE_LANE_SIZE / DCACHE_LANE_SIZE, which must be equal.
- One combinational sub-module, segre_mem_arb_picker. Inputs: three requests plus last-owner/starve state. Output: the winner as arb_owner_e. It holds the macro-dependent policy.

## Test plan
- ic_req_i only, addr 0x0000_1234; memory ready 2 cycles after strobe with data 0xA5…A5 → mem_rd_o at cycle 1, mem_addr_o 0x0000_1230, ic_done_o at cycle 4, ic_data_o 0xA5…A5.
- wb_req_i and dc_req_i raised in the same cycle → mem_wr_o first with wb_data_i; wb_done_o; then mem_rd_o for DC after the DONE/IDLE gap.
- wb_req_i and dc_req_i held continuously with ic_req_i high, macro undefined → IC granted on the 5th arbitration, after 4 losses. Counter returns to 0.
- Macro defined, all three requests held → grant order WB, DC, IC, WB, …
- rsn_i low during ARB_BUSY → all outputs 0 immediately. No done pulse. IDLE after release.
- mem_ready_i pulsed in ARB_IDLE → no state change and no done pulse.

Source files
------------

// File: rtl/segre_mem_arbiter_pkg.sv
// Shared types and defaults for the Segre main-memory arbiter.
package segre_mem_arbiter_pkg;

  localparam int ICACHE_LANE_SIZE     = 128;
  localparam int DCACHE_LANE_SIZE     = 128;
  localparam int MEM_ARB_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IC   = 2'd1,
    OWN_DC   = 2'd2,
    OWN_WB   = 2'd3
  } arb_owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_fsm_state_e;

endpackage

// File: rtl/segre_mem_arb_picker.sv
// Combinational winner selection. SEGRE_MEM_ARB_RR_EN selects round-robin,
// otherwise fixed priority WB > DC > IC with an IC starvation override.
module segre_mem_arb_picker
  import segre_mem_arbiter_pkg::*;
(
  input  logic       ic_req,
  input  logic       dc_req,
  input  logic       wb_req,
  input  arb_owner_e last_owner,
  input  logic       starved,
  output arb_owner_e winner
);

`ifdef SEGRE_MEM_ARB_RR_EN
  logic unused_starved;
  assign unused_starved = starved;

  // Search order WB -> DC -> IC, starting just after the previous winner.
  always_comb begin
    winner = OWN_NONE;
    case (last_owner)
      OWN_WB: begin
        if      (dc_req) winner = OWN_DC;
        else if (ic_req) winner = OWN_IC;
        else if (wb_req) winner = OWN_WB;
      end
      OWN_DC: begin
        if      (ic_req) winner = OWN_IC;
        else if (wb_req) winner = OWN_WB;
        else if (dc_req) winner = OWN_DC;
      end
      default: begin
        if      (wb_req) winner = OWN_WB;
        else if (dc_req) winner = OWN_DC;
        else if (ic_req) winner = OWN_IC;
      end
    endcase
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = ^last_owner;

  always_comb begin
    winner = OWN_NONE;
    if      (ic_req && starved) winner = OWN_IC;
    else if (wb_req)            winner = OWN_WB;
    else if (dc_req)            winner = OWN_DC;
    else if (ic_req)            winner = OWN_IC;
  end
`endif

endmodule

// File: rtl/segre_mem_arbiter.sv
// Serialises IC fill, DC fill and DC writeback onto the single memory lane port.
// Arbitration policy is chosen by SEGRE_MEM_ARB_RR_EN (see segre_mem_arb_picker).
module segre_mem_arbiter
  import segre_mem_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE    = 32,
  parameter int LANE_SIZE    = ICACHE_LANE_SIZE,
  parameter int STARVE_LIMIT = MEM_ARB_STARVE_LIMIT
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 ic_req_i,
  input  logic [ADDR_SIZE-1:0] ic_addr_i,
  output logic                 ic_done_o,
  output logic [LANE_SIZE-1:0] ic_data_o,
  input  logic                 dc_req_i,
  input  logic [ADDR_SIZE-1:0] dc_addr_i,
  output logic                 dc_done_o,
  output logic [LANE_SIZE-1:0] dc_data_o,
  input  logic                 wb_req_i,
  input  logic [ADDR_SIZE-1:0] wb_addr_i,
  input  logic [LANE_SIZE-1:0] wb_data_i,
  output logic                 wb_done_o,
  output logic                 mem_rd_o,
  output logic                 mem_wr_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [LANE_SIZE-1:0] mem_wr_data_o,
  input  logic [LANE_SIZE-1:0] mem_rd_data_i,
  input  logic                 mem_ready_i,
  output logic                 busy_o,
  output arb_owner_e           owner_o
);

  arb_fsm_state_e       state, state_next;
  arb_owner_e           owner, last_owner, winner;
  logic                 starved;
  logic                 grant, complete;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic                 mem_rd, mem_wr;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [LANE_SIZE-1:0] wr_data, ic_data, dc_data;

  segre_mem_arb_picker u_picker (
    .ic_req     (ic_req_i),
    .dc_req     (dc_req_i),
    .wb_req     (wb_req_i),
    .last_owner (last_owner),
    .starved    (starved),
    .winner     (winner)
  );

  assign grant    = (state == ARB_IDLE) && (winner != OWN_NONE);
  assign complete = (state == ARB_BUSY) && mem_ready_i;

`ifdef SEGRE_MEM_ARB_RR_EN
  assign starved = 1'b0;
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign starved = (starve_cnt == SW'(STARVE_LIMIT));

  // Counts arbitrations the IC lost while asking; saturates at the limit.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (winner == OWN_IC)         starve_cnt <= '0;
      else if (ic_req_i && !starved) starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    sel_addr = '0;
    case (winner)
      OWN_IC:  sel_addr = ic_addr_i;
      OWN_DC:  sel_addr = dc_addr_i;
      OWN_WB:  sel_addr = wb_addr_i;
      default: sel_addr = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) state <= ARB_IDLE;
    else        state <= state_next;
  end

  // DONE always returns to IDLE so the finishing owner cannot be re-granted at once.
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: if (winner != OWN_NONE) state_next = ARB_BUSY;
      ARB_BUSY: if (mem_ready_i)        state_next = ARB_DONE;
      ARB_DONE: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      owner      <= OWN_NONE;
      last_owner <= OWN_NONE;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      wr_data    <= '0;
      ic_data    <= '0;
      dc_data    <= '0;
    end else begin
      if (grant) begin
        owner      <= winner;
        last_owner <= winner;
        mem_rd     <= (winner != OWN_WB);
        mem_wr     <= (winner == OWN_WB);
        mem_addr   <= {sel_addr[ADDR_SIZE-1:4], 4'b0000};
        if (winner == OWN_WB) wr_data <= wb_data_i;
      end
      if (complete) begin
        mem_rd <= 1'b0;
        mem_wr <= 1'b0;
        if (owner == OWN_IC) ic_data <= mem_rd_data_i;
        if (owner == OWN_DC) dc_data <= mem_rd_data_i;
      end
      if (state == ARB_DONE) owner <= OWN_NONE;
    end
  end

  assign ic_done_o     = (state == ARB_DONE) && (owner == OWN_IC);
  assign dc_done_o     = (state == ARB_DONE) && (owner == OWN_DC);
  assign wb_done_o     = (state == ARB_DONE) && (owner == OWN_WB);
  assign ic_data_o     = ic_data;
  assign dc_data_o     = dc_data;
  assign mem_rd_o      = mem_rd;
  assign mem_wr_o      = mem_wr;
  assign mem_addr_o    = mem_addr;
  assign mem_wr_data_o = wr_data;
  assign busy_o        = (state == ARB_BUSY);
  assign owner_o       = owner;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Self-checking bench for segre_mem_arbiter with a behavioural arbitration model.
module tb_segre_mem_arbiter;
  import segre_mem_arbiter_pkg::*;

  localparam int SL = 4;
  typedef logic [127:0] lane_t;

  logic        clk_i, rsn_i;
  logic        ic_req_i, dc_req_i, wb_req_i;
  logic [31:0] ic_addr_i, dc_addr_i, wb_addr_i;
  lane_t       wb_data_i, mem_rd_data_i;
  logic        mem_ready_i;
  logic        ic_done_o, dc_done_o, wb_done_o, mem_rd_o, mem_wr_o, busy_o;
  lane_t       ic_data_o, dc_data_o, mem_wr_data_o;
  logic [31:0] mem_addr_o;
  arb_owner_e  owner_o;

  int total = 0;
  int bad   = 0;

  segre_mem_arbiter #(.ADDR_SIZE(32), .LANE_SIZE(128), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_done_o(ic_done_o), .ic_data_o(ic_data_o),
    .dc_req_i(dc_req_i), .dc_addr_i(dc_addr_i), .dc_done_o(dc_done_o), .dc_data_o(dc_data_o),
    .wb_req_i(wb_req_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_done_o(wb_done_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_rd_data_i(mem_rd_data_i), .mem_ready_i(mem_ready_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model state
  arb_owner_e m_last;
  int         m_cnt;

  function automatic lane_t rand_lane();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic arb_owner_e model_pick(bit ic, bit dc, bit wb);
`ifdef SEGRE_MEM_ARB_RR_EN
    arb_owner_e order [3];
    bit         req   [3];
    int         start;
    order[0] = OWN_WB; order[1] = OWN_DC; order[2] = OWN_IC;
    req[0] = wb; req[1] = dc; req[2] = ic;
    start = 0;
    for (int k = 0; k < 3; k++) if (order[k] == m_last) start = (k + 1) % 3;
    for (int k = 0; k < 3; k++) if (req[(start + k) % 3]) return order[(start + k) % 3];
    return OWN_NONE;
`else
    if (ic && m_cnt >= SL) return OWN_IC;
    if (wb) return OWN_WB;
    if (dc) return OWN_DC;
    if (ic) return OWN_IC;
    return OWN_NONE;
`endif
  endfunction

  function automatic void model_update(arb_owner_e w, bit ic_pending);
    if (w == OWN_IC) m_cnt = 0;
    else if (ic_pending && m_cnt < SL) m_cnt = m_cnt + 1;
    m_last = w;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rsn_i = 1'b0;
    ic_req_i = 0; dc_req_i = 0; wb_req_i = 0;
    ic_addr_i = 0; dc_addr_i = 0; wb_addr_i = 0; wb_data_i = 0;
    mem_ready_i = 0; mem_rd_data_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rsn_i = 1'b1;
    m_last = OWN_NONE;
    m_cnt  = 0;
  endtask

  // Memory model: waits for a strobe, reports what it saw, answers after dly cycles.
  // Returns in the cycle where the done pulse is expected.
  task automatic mem_respond(input int dly, input lane_t data, output bit tmo,
                             output logic rd, output logic wr, output logic [31:0] addr,
                             output lane_t wdata, output arb_owner_e own);
    tmo = 1; rd = 0; wr = 0; addr = 0; wdata = 0; own = OWN_NONE;
    for (int i = 0; i < 50; i++) begin
      if (mem_rd_o || mem_wr_o) begin
        tmo = 0;
        break;
      end
      tick();
    end
    if (tmo) return;
    rd = mem_rd_o; wr = mem_wr_o; addr = mem_addr_o; wdata = mem_wr_data_o; own = owner_o;
    repeat (dly) tick();
    mem_ready_i = 1'b1;
    mem_rd_data_i = data;
    tick();
    mem_ready_i = 1'b0;
    mem_rd_data_i = '0;
  endtask

  task automatic test_reset();
    rsn_i = 1'b0;
    #3;
    total++;
    if ({ic_done_o, dc_done_o, wb_done_o, mem_rd_o, mem_wr_o, busy_o, owner_o, mem_addr_o,
         mem_wr_data_o, ic_data_o, dc_data_o} !== '0)
      begin bad++; $display("FAIL reset_outputs: got nonzero outputs, want all 0"); end
    apply_reset();
    tick();
    total++;
    if ({busy_o, owner_o} !== 3'b000)
      begin bad++; $display("FAIL reset_idle: got busy=%0b owner=%0d want 0 0", busy_o, owner_o); end
  endtask

  task automatic test_ic_fill();
    lane_t a5 = {16{8'hA5}};
    apply_reset();
    ic_addr_i = 32'h0000_1234; ic_req_i = 1;        // cycle 0
    tick();                                         // cycle 1
    total++;
    if ({mem_rd_o, mem_wr_o, busy_o, owner_o} !== {3'b101, OWN_IC})
      begin bad++; $display("FAIL ic_strobe: got rd=%0b wr=%0b busy=%0b owner=%0d want 1 0 1 1", mem_rd_o, mem_wr_o, busy_o, owner_o); end
    total++;
    if (mem_addr_o !== 32'h0000_1230)
      begin bad++; $display("FAIL ic_addr: got %h want 00001230", mem_addr_o); end
    tick();                                         // cycle 2
    ic_addr_i = 32'hFFFF_FFFF;
    tick();                                         // cycle 3
    total++;
    if ({mem_rd_o, mem_addr_o} !== {1'b1, 32'h0000_1230})
      begin bad++; $display("FAIL ic_addr_hold: got rd=%0b addr=%h want 1 00001230", mem_rd_o, mem_addr_o); end
    mem_ready_i = 1; mem_rd_data_i = a5;
    tick();                                         // cycle 4
    mem_ready_i = 0; mem_rd_data_i = '0;
    total++;
    if ({ic_done_o, dc_done_o, wb_done_o, mem_rd_o, busy_o} !== 5'b10000)
      begin bad++; $display("FAIL ic_done: got done=%b rd=%0b busy=%0b want 100 0 0", {ic_done_o, dc_done_o, wb_done_o}, mem_rd_o, busy_o); end
    total++;
    if (ic_data_o !== a5)
      begin bad++; $display("FAIL ic_data: got %h want %h", ic_data_o, a5); end
    tick();                                         // cycle 5
    ic_req_i = 0;
    total++;
    if ({ic_done_o, busy_o, ic_data_o} !== {2'b00, a5})
      begin bad++; $display("FAIL ic_after_done: got done=%0b busy=%0b data=%h", ic_done_o, busy_o, ic_data_o); end
    tick(); tick();
    total++;
    if ({busy_o, mem_rd_o} !== 2'b00)
      begin bad++; $display("FAIL ic_no_regrant: got busy=%0b rd=%0b want 0 0", busy_o, mem_rd_o); end
  endtask

  task automatic test_wb_before_dc();
    bit tmo; logic rd, wr; logic [31:0] ad; lane_t wd, rdat; arb_owner_e own;
    apply_reset();
    wb_addr_i = $urandom; wb_data_i = rand_lane(); dc_addr_i = $urandom;
    wb_req_i = 1; dc_req_i = 1;
    mem_respond(1, rand_lane(), tmo, rd, wr, ad, wd, own);
    total++;
    if ({tmo, rd, wr, own} !== {3'b001, OWN_WB} || ad !== {wb_addr_i[31:4], 4'h0} || wd !== wb_data_i)
      begin bad++; $display("FAIL wb_first: got tmo=%0b rd=%0b wr=%0b own=%0d addr=%h", tmo, rd, wr, own, ad); end
    total++;
    if ({ic_done_o, dc_done_o, wb_done_o} !== 3'b001)
      begin bad++; $display("FAIL wb_done: got %b want 001", {ic_done_o, dc_done_o, wb_done_o}); end
    tick();
    wb_req_i = 0;
    total++;
    if ({busy_o, mem_rd_o, mem_wr_o} !== 3'b000)
      begin bad++; $display("FAIL wb_dc_gap: got busy=%0b rd=%0b wr=%0b want 000", busy_o, mem_rd_o, mem_wr_o); end
    rdat = rand_lane();
    mem_respond(0, rdat, tmo, rd, wr, ad, wd, own);
    total++;
    if ({tmo, rd, wr, own} !== {3'b010, OWN_DC} || ad !== {dc_addr_i[31:4], 4'h0})
      begin bad++; $display("FAIL dc_second: got tmo=%0b rd=%0b wr=%0b own=%0d addr=%h", tmo, rd, wr, own, ad); end
    total++;
    if ({dc_done_o, dc_data_o} !== {1'b1, rdat})
      begin bad++; $display("FAIL dc_done_data: got done=%0b data=%h want 1 %h", dc_done_o, dc_data_o, rdat); end
    tick();
    dc_req_i = 0;
  endtask

`ifdef SEGRE_MEM_ARB_RR_EN
  task automatic test_round_robin();
    bit tmo; logic rd, wr; logic [31:0] ad; lane_t wd; arb_owner_e own, exp;
    apply_reset();
    ic_req_i = 1; dc_req_i = 1; wb_req_i = 1;
    for (int g = 0; g < 6; g++) begin
      exp = (g % 3 == 0) ? OWN_WB : (g % 3 == 1) ? OWN_DC : OWN_IC;
      mem_respond($urandom_range(0, 2), rand_lane(), tmo, rd, wr, ad, wd, own);
      total++;
      if (tmo || own !== exp)
        begin bad++; $display("FAIL rr_grant%0d: got tmo=%0b owner=%0d want %0d", g, tmo, own, exp); end
    end
    ic_req_i = 0; dc_req_i = 0; wb_req_i = 0;
    tick();
  endtask
`else
  task automatic test_starvation();
    bit tmo; logic rd, wr; logic [31:0] ad; lane_t wd; arb_owner_e own, exp;
    apply_reset();
    ic_req_i = 1; dc_req_i = 1; wb_req_i = 1;
    for (int g = 0; g < 10; g++) begin
      exp = (g % 5 == 4) ? OWN_IC : OWN_WB;
      mem_respond($urandom_range(0, 2), rand_lane(), tmo, rd, wr, ad, wd, own);
      total++;
      if (tmo || own !== exp)
        begin bad++; $display("FAIL starve_grant%0d: got tmo=%0b owner=%0d want %0d", g, tmo, own, exp); end
    end
    ic_req_i = 0; dc_req_i = 0; wb_req_i = 0;
    tick();
  endtask
`endif

  task automatic test_reset_mid_busy();
    bit tmo; logic rd, wr; logic [31:0] ad; lane_t wd, rdat; arb_owner_e own;
    apply_reset();
    dc_addr_i = $urandom; dc_req_i = 1; rdat = rand_lane();
    mem_respond(0, rdat, tmo, rd, wr, ad, wd, own);
    total++;
    if (dc_data_o !== rdat)
      begin bad++; $display("FAIL mid_pre_fill: got %h want %h", dc_data_o, rdat); end
    tick();
    dc_req_i = 0;
    ic_addr_i = $urandom; ic_req_i = 1;
    tick();
    total++;
    if (busy_o !== 1'b1)
      begin bad++; $display("FAIL mid_busy: got busy=%0b want 1", busy_o); end
    #2 rsn_i = 1'b0;
    #1;
    total++;
    if ({ic_done_o, dc_done_o, wb_done_o, mem_rd_o, mem_wr_o, busy_o, owner_o, mem_addr_o,
         mem_wr_data_o, ic_data_o, dc_data_o} !== '0)
      begin bad++; $display("FAIL mid_reset_outputs: got nonzero outputs, want all 0"); end
    ic_req_i = 0;
    @(posedge clk_i);
    #1 rsn_i = 1'b1;
    mem_ready_i = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      mem_ready_i = 0;
      total++;
      if ({ic_done_o, dc_done_o, wb_done_o, busy_o} !== 4'b0000)
        begin bad++; $display("FAIL mid_after_release%0d: got done=%b busy=%0b want 000 0", c, {ic_done_o, dc_done_o, wb_done_o}, busy_o); end
    end
  endtask

  task automatic test_ready_in_idle();
    apply_reset();
    tick();
    mem_ready_i = 1; mem_rd_data_i = rand_lane();
    tick();
    mem_ready_i = 0; mem_rd_data_i = '0;
    for (int c = 0; c < 2; c++) begin
      total++;
      if ({ic_done_o, dc_done_o, wb_done_o, busy_o, mem_rd_o, mem_wr_o, owner_o, ic_data_o, dc_data_o} !== '0)
        begin bad++; $display("FAIL idle_ready%0d: got done=%b busy=%0b owner=%0d", c, {ic_done_o, dc_done_o, wb_done_o}, busy_o, owner_o); end
      tick();
    end
  endtask

  task automatic test_random();
    bit tmo; logic rd, wr; logic [31:0] ad; lane_t wd, rdat, m_ic, m_dc; arb_owner_e own, exp;
    bit p_ic, p_dc, p_wb;
    logic [31:0] exp_addr;
    apply_reset();
    p_ic = 0; p_dc = 0; p_wb = 0; m_ic = '0; m_dc = '0;
    for (int t = 0; t < 40; t++) begin
      if (!p_wb && $urandom_range(0, 1) == 1) begin p_wb = 1; wb_addr_i = $urandom; wb_data_i = rand_lane(); end
      if (!p_dc && $urandom_range(0, 1) == 1) begin p_dc = 1; dc_addr_i = $urandom; end
      if (!p_ic && $urandom_range(0, 1) == 1) begin p_ic = 1; ic_addr_i = $urandom; end
      if (!p_ic && !p_dc && !p_wb) begin p_ic = 1; ic_addr_i = $urandom; end
      ic_req_i = p_ic; dc_req_i = p_dc; wb_req_i = p_wb;
      exp = model_pick(p_ic, p_dc, p_wb);
      exp_addr = (exp == OWN_WB) ? wb_addr_i : (exp == OWN_DC) ? dc_addr_i : ic_addr_i;
      exp_addr[3:0] = 4'h0;
      rdat = rand_lane();
      mem_respond($urandom_range(0, 3), rdat, tmo, rd, wr, ad, wd, own);
      total++;
      if (tmo || own !== exp || rd !== (exp != OWN_WB) || wr !== (exp == OWN_WB) || ad !== exp_addr)
        begin bad++; $display("FAIL rnd_grant%0d: got tmo=%0b own=%0d rd=%0b wr=%0b addr=%h want own=%0d addr=%h", t, tmo, own, rd, wr, ad, exp, exp_addr); end
      if (exp == OWN_WB) begin
        total++;
        if (wd !== wb_data_i)
          begin bad++; $display("FAIL rnd_wdata%0d: got %h want %h", t, wd, wb_data_i); end
      end
      if (exp == OWN_IC) m_ic = rdat;
      if (exp == OWN_DC) m_dc = rdat;
      total++;
      if ({ic_done_o, dc_done_o, wb_done_o} !== {exp == OWN_IC, exp == OWN_DC, exp == OWN_WB})
        begin bad++; $display("FAIL rnd_done%0d: got %b for owner %0d", t, {ic_done_o, dc_done_o, wb_done_o}, exp); end
      total++;
      if ({ic_data_o, dc_data_o} !== {m_ic, m_dc})
        begin bad++; $display("FAIL rnd_data%0d: got ic=%h dc=%h want ic=%h dc=%h", t, ic_data_o, dc_data_o, m_ic, m_dc); end
      model_update(exp, p_ic);
      tick();
      if (exp == OWN_IC) p_ic = 0;
      if (exp == OWN_DC) p_dc = 0;
      if (exp == OWN_WB) p_wb = 0;
      ic_req_i = p_ic; dc_req_i = p_dc; wb_req_i = p_wb;
    end
    ic_req_i = 0; dc_req_i = 0; wb_req_i = 0;
    tick();
  endtask

  initial begin
    ic_req_i = 0; dc_req_i = 0; wb_req_i = 0;
    ic_addr_i = 0; dc_addr_i = 0; wb_addr_i = 0; wb_data_i = 0;
    mem_ready_i = 0; mem_rd_data_i = 0; rsn_i = 1;
    m_last = OWN_NONE; m_cnt = 0;
    test_reset();
    test_ic_fill();
    test_wb_before_dc();
`ifdef SEGRE_MEM_ARB_RR_EN
    test_round_robin();
`else
    test_starvation();
`endif
    test_reset_mid_busy();
    test_ready_in_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
